// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp -- parametrised multi-port CPU register file
//
// Purpose:
//   Register file for the CPU32 pipeline, sitting between decode and
//   writeback. It has two write ports (B has priority over A), N_RD
//   combinational read ports, and a per-register scoreboard of pending-write
//   busy bits. A sequenced clear engine zeroes one register per cycle.
//   Register 0 is hardwired to zero and is never busy.
//
// Parameters:
//   WIDTH  register word width
//   DEPTH  number of registers (power of two, >= 2)
//   N_RD   number of read ports (1..4)
//
// Ports:
//   clk_cpu                   clock, all state updates on the rising edge
//   reset                     synchronous active-high reset
//   rd_adrs   [N_RD*AW]       packed read addresses (port k: [k*AW +: AW])
//   rd_data   [N_RD*WIDTH]    packed read data, combinational
//   rd_busy   [N_RD]          busy bit of the addressed register, combinational
//   wr_en_a/wr_adrs_a/wr_data_a   write port A
//   wr_en_b/wr_adrs_b/wr_data_b   write port B (wins over A on same address)
//   rsv_en/rsv_adrs           reserve: mark a register as pending write
//   clr_req                   start the sequenced clear
//   clr_busy                  clear engine active
//   clr_done                  one-cycle pulse in the last clear cycle
//
// Build option:
//   REGFILE_BYPASS_EN  when defined, a read whose address matches a write in
//                      the same cycle returns the write data (B before A)
//                      and reports not-busy.
// -----------------------------------------------------------------------------
module regfile_mp #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    parameter int N_RD  = 2,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                  clk_cpu,
    input  logic                  reset,
    input  logic [N_RD*AW-1:0]    rd_adrs,
    output logic [N_RD*WIDTH-1:0] rd_data,
    output logic [N_RD-1:0]       rd_busy,
    input  logic                  wr_en_a,
    input  logic [AW-1:0]         wr_adrs_a,
    input  logic [WIDTH-1:0]      wr_data_a,
    input  logic                  wr_en_b,
    input  logic [AW-1:0]         wr_adrs_b,
    input  logic [WIDTH-1:0]      wr_data_b,
    input  logic                  rsv_en,
    input  logic [AW-1:0]         rsv_adrs,
    input  logic                  clr_req,
    output logic                  clr_busy,
    output logic                  clr_done
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam logic [AW-1:0] ADR_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0] ADR_LAST = AW'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [AW-1:0]     cnt_q, cnt_d;
    logic              clr_done_q, clr_done_d;
    logic [WIDTH-1:0]  regs_q [DEPTH];
    logic [WIDTH-1:0]  regs_d [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;

    logic wr_a_s, wr_b_s, rsv_s;

    // Qualified write/reserve strobes: register 0 and the clear phase drop them.
    always_comb begin
        wr_a_s = 1'b0;
        wr_b_s = 1'b0;
        rsv_s  = 1'b0;
        if (state_q == ST_IDLE) begin
            wr_a_s = wr_en_a && (wr_adrs_a != ADR_ZERO);
            wr_b_s = wr_en_b && (wr_adrs_b != ADR_ZERO);
            rsv_s  = rsv_en  && (rsv_adrs  != ADR_ZERO);
        end else begin
            wr_a_s = 1'b0;
            wr_b_s = 1'b0;
            rsv_s  = 1'b0;
        end
    end

    // Clear FSM next state, counter and registered done pulse.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        clr_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clr_req) begin
                    state_d = ST_CLEAR;
                    cnt_d   = ADR_ZERO;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                cnt_d = cnt_q + {{(AW-1){1'b0}}, 1'b1};
                if (cnt_q == ADR_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_CLEAR;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = ADR_ZERO;
            end
        endcase
        // Registered so the pulse lands in the cycle the counter sits at DEPTH-1.
        if ((state_d == ST_CLEAR) && (cnt_d == ADR_LAST)) begin
            clr_done_d = 1'b1;
        end else begin
            clr_done_d = 1'b0;
        end
    end

    // Register array and scoreboard next state: port B applied after A so it
    // wins, reserve applied last so it beats a same-cycle write.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        if (state_q == ST_CLEAR) begin
            regs_d[cnt_q] = {WIDTH{1'b0}};
            busy_d[cnt_q] = 1'b0;
        end else begin
            if (wr_a_s) begin
                regs_d[wr_adrs_a] = wr_data_a;
                busy_d[wr_adrs_a] = 1'b0;
            end else begin
                busy_d = busy_d;
            end
            if (wr_b_s) begin
                regs_d[wr_adrs_b] = wr_data_b;
                busy_d[wr_adrs_b] = 1'b0;
            end else begin
                busy_d = busy_d;
            end
            if (rsv_s) begin
                busy_d[rsv_adrs] = 1'b1;
            end else begin
                busy_d = busy_d;
            end
        end
        regs_d[0] = {WIDTH{1'b0}};
        busy_d[0] = 1'b0;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_cpu) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= ADR_ZERO;
            clr_done_q <= 1'b0;
            busy_q     <= {DEPTH{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            clr_done_q <= clr_done_d;
            busy_q     <= busy_d;
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign clr_busy = (state_q == ST_CLEAR);
    assign clr_done = clr_done_q;

    for (genvar k = 0; k < N_RD; k++) begin : g_rd
        logic [AW-1:0]    adr_s;
        logic [WIDTH-1:0] data_s;
        logic             busy_s;

        assign adr_s = rd_adrs[k*AW +: AW];

        // Read mux for port k (register 0 stores zero, so no special case).
        always_comb begin
            data_s = regs_q[adr_s];
            busy_s = busy_q[adr_s];
`ifdef REGFILE_BYPASS_EN
            if (wr_b_s && (wr_adrs_b == adr_s)) begin
                data_s = wr_data_b;
                busy_s = 1'b0;
            end else if (wr_a_s && (wr_adrs_a == adr_s)) begin
                data_s = wr_data_a;
                busy_s = 1'b0;
            end else begin
                data_s = regs_q[adr_s];
                busy_s = busy_q[adr_s];
            end
`endif
        end

        assign rd_data[k*WIDTH +: WIDTH] = data_s;
        assign rd_busy[k]                = busy_s;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp -- self-checking bench for regfile_mp (default parameters).
// A behavioural model (arrays plus a clear-progress count) predicts every
// read port, clr_busy and clr_done each cycle; directed sequences cover the
// documented corner cases, followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_regfile_mp;

    localparam int WIDTH = 32;
    localparam int DEPTH = 32;
    localparam int N_RD  = 2;
    localparam int AW    = 5;

    logic                  clk_cpu = 1'b0;
    logic                  reset;
    logic [N_RD*AW-1:0]    rd_adrs;
    logic [N_RD*WIDTH-1:0] rd_data;
    logic [N_RD-1:0]       rd_busy;
    logic                  wr_en_a, wr_en_b, rsv_en, clr_req;
    logic [AW-1:0]         wr_adrs_a, wr_adrs_b, rsv_adrs;
    logic [WIDTH-1:0]      wr_data_a, wr_data_b;
    logic                  clr_busy, clr_done;

    regfile_mp #(.WIDTH(WIDTH), .DEPTH(DEPTH), .N_RD(N_RD)) dut (
        .clk_cpu  (clk_cpu),
        .reset    (reset),
        .rd_adrs  (rd_adrs),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en_a  (wr_en_a),
        .wr_adrs_a(wr_adrs_a),
        .wr_data_a(wr_data_a),
        .wr_en_b  (wr_en_b),
        .wr_adrs_b(wr_adrs_b),
        .wr_data_b(wr_data_b),
        .rsv_en   (rsv_en),
        .rsv_adrs (rsv_adrs),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .clr_done (clr_done)
    );

    always #5 clk_cpu = ~clk_cpu;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    logic [WIDTH-1:0] m_regs [DEPTH];
    bit               m_busy [DEPTH];
    bit               m_clearing;
    int               m_cleared;     // registers already zeroed in this clear
    int               busy_cycles;
    int               done_seen;
    int               done_at;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit hits(input logic en, input logic [AW-1:0] wa, input int a);
        return !m_clearing && en && (wa != 0) && (int'(wa) == a);
    endfunction

    function automatic logic [WIDTH-1:0] exp_data(input int a);
`ifdef REGFILE_BYPASS_EN
        if (hits(wr_en_b, wr_adrs_b, a)) return wr_data_b;
        if (hits(wr_en_a, wr_adrs_a, a)) return wr_data_a;
`endif
        return (a == 0) ? '0 : m_regs[a];
    endfunction

    function automatic logic exp_busy(input int a);
`ifdef REGFILE_BYPASS_EN
        if (hits(wr_en_b, wr_adrs_b, a) || hits(wr_en_a, wr_adrs_a, a)) return 1'b0;
`endif
        return (a == 0) ? 1'b0 : m_busy[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
        m_clearing = 1'b0;
        m_cleared  = 0;
    endtask

    // One clock: check all outputs mid-cycle, then advance the model at the edge.
    task automatic step();
        @(negedge clk_cpu);
        for (int k = 0; k < N_RD; k++) begin
            int a;
            a = int'(rd_adrs[k*AW +: AW]);
            check_eq($sformatf("rd_data[%0d]@%0d", k, a), 64'(rd_data[k*WIDTH +: WIDTH]), 64'(exp_data(a)));
            check_eq($sformatf("rd_busy[%0d]@%0d", k, a), 64'(rd_busy[k]), 64'(exp_busy(a)));
        end
        check_eq("clr_busy", 64'(clr_busy), 64'(m_clearing));
        check_eq("clr_done", 64'(clr_done), 64'(m_clearing && (m_cleared == DEPTH - 1)));
        if (clr_busy === 1'b1) busy_cycles++;
        if (clr_done === 1'b1) begin
            done_seen++;
            done_at = busy_cycles;
        end
        @(posedge clk_cpu);
        if (reset) begin
            model_reset();
        end else if (m_clearing) begin
            m_regs[m_cleared] = '0;
            m_busy[m_cleared] = 1'b0;
            m_cleared++;
            if (m_cleared == DEPTH) m_clearing = 1'b0;
        end else begin
            if (wr_en_a && wr_adrs_a != 0) begin
                m_regs[wr_adrs_a] = wr_data_a;
                m_busy[wr_adrs_a] = 1'b0;
            end
            if (wr_en_b && wr_adrs_b != 0) begin
                m_regs[wr_adrs_b] = wr_data_b;
                m_busy[wr_adrs_b] = 1'b0;
            end
            if (rsv_en && rsv_adrs != 0) m_busy[rsv_adrs] = 1'b1;
            if (clr_req) begin
                m_clearing = 1'b1;
                m_cleared  = 0;
            end
        end
        #1;
    endtask

    task automatic idle_inputs();
        reset = 1'b0; wr_en_a = 1'b0; wr_en_b = 1'b0; rsv_en = 1'b0; clr_req = 1'b0;
    endtask

    task automatic sweep_reads();
        for (int a = 0; a < DEPTH; a++) begin
            rd_adrs = {AW'(a), AW'(DEPTH - 1 - a)};
            step();
        end
    endtask

    initial begin
        idle_inputs();
        wr_adrs_a = '0; wr_adrs_b = '0; rsv_adrs = '0; rd_adrs = '0;
        wr_data_a = '0; wr_data_b = '0;
        busy_cycles = 0; done_seen = 0; done_at = 0;
        reset = 1'b1;
        repeat (2) @(posedge clk_cpu);
        #1;
        model_reset();
        reset = 1'b0;

        // 1: everything zero after reset
        sweep_reads();

        // 2: same-address dual write, B wins; register 0 ignores writes
        wr_en_a = 1'b1; wr_adrs_a = 5'd5; wr_data_a = 32'h1234_5678;
        wr_en_b = 1'b1; wr_adrs_b = 5'd5; wr_data_b = 32'hCAFE_F00D;
        step();
        idle_inputs();
        rd_adrs = {5'd5, 5'd5};
        #1;
        check_eq("dual_wr_b_wins", 64'(rd_data[WIDTH-1:0]), 64'h0000_0000_CAFE_F00D);
        check_eq("same_adr_ports", 64'(rd_data[2*WIDTH-1:WIDTH]), 64'h0000_0000_CAFE_F00D);
        wr_en_a = 1'b1; wr_adrs_a = 5'd0; wr_data_a = 32'hFFFF_FFFF;
        step();
        idle_inputs();
        rd_adrs = {5'd0, 5'd0};
        #1;
        check_eq("reg0_zero", 64'(rd_data[WIDTH-1:0]), 64'h0);
        step();

        // 3: scoreboard reserve/write interplay
        rsv_en = 1'b1; rsv_adrs = 5'd7; rd_adrs = {5'd7, 5'd7};
        step();
        idle_inputs();
        #1;
        check_eq("rsv_sets_busy", 64'(rd_busy[0]), 64'h1);
        wr_en_a = 1'b1; wr_adrs_a = 5'd7; wr_data_a = 32'h0000_0077;
        rsv_en = 1'b1; rsv_adrs = 5'd7;
        step();
        idle_inputs();
        #1;
        check_eq("rsv_beats_wr", 64'(rd_busy[0]), 64'h1);
        wr_en_b = 1'b1; wr_adrs_b = 5'd7; wr_data_b = 32'h0000_0078;
        step();
        idle_inputs();
        #1;
        check_eq("wr_clears_busy", 64'(rd_busy[0]), 64'h0);
        rsv_en = 1'b1; rsv_adrs = 5'd0; rd_adrs = {5'd0, 5'd0};
        step();
        idle_inputs();
        #1;
        check_eq("rsv_reg0", 64'(rd_busy[0]), 64'h0);
        step();

        // 4: fill, then a full clear; a mid-clear write is lost
        for (int a = 1; a < DEPTH; a++) begin
            wr_en_a = 1'b1; wr_adrs_a = AW'(a); wr_data_a = 32'hA000_0000 | 32'(a);
            rsv_en = 1'b1; rsv_adrs = AW'(DEPTH - a);
            rd_adrs = {AW'(a), AW'(a - 1)};
            step();
        end
        idle_inputs();
        busy_cycles = 0; done_seen = 0; done_at = 0;
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int c = 0; c < DEPTH + 3; c++) begin
            wr_en_a = (c == 15); wr_adrs_a = 5'd3; wr_data_a = 32'h3333_3333;
            rd_adrs = {5'd3, AW'(c % DEPTH)};
            step();
        end
        idle_inputs();
        check_eq("clr_len", 64'(busy_cycles), 64'(DEPTH));
        check_eq("clr_done_cnt", 64'(done_seen), 64'h1);
        check_eq("clr_done_at", 64'(done_at), 64'(DEPTH));
        sweep_reads();

        // 5: reset in the middle of a clear, then a complete clear
        wr_en_a = 1'b1; wr_adrs_a = 5'd12; wr_data_a = 32'h1212_1212;
        step();
        idle_inputs();
        busy_cycles = 0; done_seen = 0;
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        repeat (9) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        rd_adrs = {5'd12, 5'd31};
        step();
        check_eq("rst_abort_done", 64'(done_seen), 64'h0);
        check_eq("rst_abort_len", 64'(busy_cycles), 64'd10);
        busy_cycles = 0; done_seen = 0; done_at = 0;
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        repeat (DEPTH + 2) step();
        check_eq("clr2_len", 64'(busy_cycles), 64'(DEPTH));
        check_eq("clr2_done_at", 64'(done_at), 64'(DEPTH));

        // 6: same-cycle read of a write to a busy register
        wr_en_a = 1'b1; wr_adrs_a = 5'd9; wr_data_a = 32'h0000_0099;
        rsv_en = 1'b1; rsv_adrs = 5'd9;
        step();
        idle_inputs();
        wr_en_a = 1'b1; wr_adrs_a = 5'd9; wr_data_a = 32'hA5A5_A5A5;
        rd_adrs = {5'd1, 5'd9};
        #1;
`ifdef REGFILE_BYPASS_EN
        check_eq("byp_data", 64'(rd_data[WIDTH-1:0]), 64'h0000_0000_A5A5_A5A5);
        check_eq("byp_busy", 64'(rd_busy[0]), 64'h0);
`else
        check_eq("nobyp_data", 64'(rd_data[WIDTH-1:0]), 64'h0000_0000_0000_0099);
        check_eq("nobyp_busy", 64'(rd_busy[0]), 64'h1);
`endif
        step();
        idle_inputs();

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            reset     = ($urandom_range(0, 199) == 0);
            clr_req   = ($urandom_range(0, 99) == 0);
            wr_en_a   = $urandom_range(0, 1);
            wr_adrs_a = AW'($urandom_range(0, DEPTH - 1));
            wr_data_a = $urandom;
            wr_en_b   = $urandom_range(0, 1);
            wr_adrs_b = ($urandom_range(0, 3) == 0) ? wr_adrs_a : AW'($urandom_range(0, DEPTH - 1));
            wr_data_b = $urandom;
            rsv_en    = $urandom_range(0, 1);
            rsv_adrs  = ($urandom_range(0, 3) == 0) ? wr_adrs_b : AW'($urandom_range(0, DEPTH - 1));
            rd_adrs[AW-1:0]    = ($urandom_range(0, 2) == 0) ? wr_adrs_b : AW'($urandom_range(0, DEPTH - 1));
            rd_adrs[2*AW-1:AW] = ($urandom_range(0, 2) == 0) ? wr_adrs_a : AW'($urandom_range(0, DEPTH - 1));
            step();
        end
        idle_inputs();
        sweep_reads();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port CPU register file; next generation of the single-write, two-read register file.
- Adds configurable width, depth and read-port count, plus a second write port.
- Adds a per-register scoreboard (pending-write busy bits) and a sequenced clear engine.
- Sits between decode (read ports, reservations) and writeback (write ports) in the CPU32 pipeline.

Parameters:
- WIDTH, 32: register word width in bits.
- DEPTH, 32: number of registers; power of two, at least 2. Localparam AW = $clog2(DEPTH).
- N_RD, 2: number of read ports, 1 to 4.

Ports:
- clk_cpu  input  1  CPU clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- rd_adrs  input  N_RD*AW  packed read addresses; port k uses bits [k*AW +: AW].
- rd_data  output  N_RD*WIDTH  packed read data; port k uses bits [k*WIDTH +: WIDTH]. Combinational.
- rd_busy  output  N_RD  per read port: addressed register has a pending write. Combinational.
- wr_en_a  input  1  write port A enable.
- wr_adrs_a  input  AW  write port A address.
- wr_data_a  input  WIDTH  write port A data.
- wr_en_b  input  1  write port B enable; B has priority over A.
- wr_adrs_b  input  AW  write port B address.
- wr_data_b  input  WIDTH  write port B data.
- rsv_en  input  1  reserve request: mark rsv_adrs as pending.
- rsv_adrs  input  AW  register address to reserve.
- clr_req  input  1  start the sequenced clear of all registers and busy bits.
- clr_busy  output  1  clear engine active.
- clr_done  output  1  one-cycle pulse when the clear sequence completes.

Behaviour:
- Reset (synchronous, on clk_cpu edge with reset=1):
  - all registers = 0; all busy bits = 0.
  - FSM returns to IDLE; clear counter = 0.
  - clr_busy = 0, clr_done = 0.
  - Reset overrides every other input in that cycle, including mid-clear; no clr_done pulse is produced.
- Register 0 is hardwired to zero:
  - writes to it are ignored; reservations of it are ignored.
  - it always reads 0 and its rd_busy is always 0.
- Writes take effect at the next clk_cpu edge.
  - Both write ports enabled at the same nonzero address: port B data is stored.
  - Different addresses: both writes happen.
- Scoreboard:
  - A write to address X (either port) clears busy[X].
  - rsv_en sets busy[rsv_adrs].
  - Reserve and write to the same X in the same cycle: busy[X] ends at 1 (reserve wins).
- Read ports:
  - Asynchronous: rd_data[k] = regs[rd_adrs[k]].
  - rd_busy[k] = busy[rd_adrs[k]].
  - Identical addresses on multiple ports return identical values.
- Clear FSM, states IDLE and CLEAR:
  - IDLE: clr_req=1 -> CLEAR at the next edge, counter = 0.
  - CLEAR: each cycle zeroes regs[counter] and busy[counter], then counter increments.
  - Exit: the cycle counter = DEPTH-1 is the last; next state IDLE and clr_done = 1 for exactly one cycle.
  - Latency: DEPTH cycles in CLEAR from the clr_req edge to the clr_done pulse.
  - clr_busy = 1 in CLEAR, 0 in IDLE. clr_req while in CLEAR is ignored.
  - In CLEAR, writes and reservations are dropped, not queued; reads return current, possibly partially cleared, contents.
- Counter width is AW bits. It wraps to 0 after DEPTH-1; this wrap is never observable because the FSM exits at that point.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined (write-to-read forwarding):
  - If read port k's address matches an enabled write this cycle (nonzero address, FSM in IDLE), rd_data[k] returns that write data in the same cycle. Port B is used when both ports match.
  - rd_busy[k] is forced to 0 for that port in that cycle.
- Undefined:
  - Reads return stored contents only; new data becomes visible the cycle after the write edge.
  - rd_busy reflects the stored busy bits only.

Test Plan:
1. Reset, then read all addresses on all ports -> every rd_data = 0, every rd_busy = 0, clr_busy = 0.
2. wr_en_a=1, wr_adrs_a=5, data 0x1234_5678 and wr_en_b=1, wr_adrs_b=5, data 0xCAFE_F00D in the same cycle -> next cycle rd_data(addr 5) = 0xCAFE_F00D. Write 0xFFFF_FFFF to address 0 -> reads 0.
3. rsv_en at address 7 -> rd_busy=1 next cycle. Write to 7 plus reserve of 7 in the same cycle -> busy stays 1. Write alone -> busy 0. rsv_en at address 0 -> busy stays 0.
4. Fill registers 1..31 with nonzero data, pulse clr_req -> clr_busy=1 for 32 cycles, clr_done pulses once at cycle 32, all reads 0. A write to 3 issued mid-clear is lost.
5. Start a clear, assert reset at clear cycle 10 -> next cycle clr_busy=0, all registers 0, no clr_done pulse. A following clr_req runs a full 32-cycle clear.
6. With REGFILE_BYPASS_EN defined: rd_adrs port 0 = 9 while writing 0xA5A5_A5A5 to 9 with busy[9]=1 -> same cycle rd_data = 0xA5A5_A5A5 and rd_busy = 0. Undefined: old value and rd_busy=1 that cycle.
